instruction_fetch: RTL

- Fetch stage immediately upstream of the byte-addressed, little-endian instruction memory (64-bit address in, 32-bit instruction out, combinational read, returns 0 for out-of-range addresses).
- Owns the program counter and drives the memory address.
- Captures the returned instruction into the IF/ID pipeline register for the decoder.
- Handles stall, flush, branch redirect, HLT detection and fetch faults.

---
 rtl/instruction_fetch_if.sv | 35 +++
 rtl/instruction_fetch.sv | 120 ++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control inputs, instruction memory port
// and the IF/ID register bundle seen by the decoder.
interface instruction_fetch_if #(
  parameter int PC_WIDTH  = 64,
  parameter int INS_WIDTH = 32
);
  logic                 i_stall;
  logic                 i_flush;
  logic                 i_br_taken;
  logic [PC_WIDTH-1:0]  i_br_target;
  logic [PC_WIDTH-1:0]  o_imem_add;
  logic [INS_WIDTH-1:0] i_imem_ins;
  logic [PC_WIDTH-1:0]  o_ifid_pc;
  logic [PC_WIDTH-1:0]  o_ifid_pc4;
  logic [INS_WIDTH-1:0] o_ifid_ins;
  logic                 o_ifid_valid;
  logic                 o_halted;
  logic                 o_fault;

  modport master (
    input  i_stall, i_flush, i_br_taken,
    input  i_br_target, i_imem_ins,
    output o_imem_add,
    output o_ifid_pc, o_ifid_pc4, o_ifid_ins,
    output o_ifid_valid, o_halted, o_fault
  );

  modport slave (
    output i_stall, i_flush, i_br_taken,
    output i_br_target, i_imem_ins,
    input  o_imem_add,
    input  o_ifid_pc, o_ifid_pc4, o_ifid_ins,
    input  o_ifid_valid, o_halted, o_fault
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory
// and fills the IF/ID register; handles halt and fetch faults.
module instruction_fetch #(
  parameter int                 PC_WIDTH  = 64,
  parameter int                 INS_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                 IMEM_SIZE = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  instruction_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT,
    FAULT
  } state_t;

  localparam logic [PC_WIDTH-1:0] LP_LAST =
    PC_WIDTH'(IMEM_SIZE - 4);

  state_t               r_state;
  state_t               w_state_nx;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [PC_WIDTH-1:0]  w_pc_nx;
  logic [PC_WIDTH-1:0]  r_ifid_pc;
  logic [PC_WIDTH-1:0]  w_ifid_pc_nx;
  logic [PC_WIDTH-1:0]  r_ifid_pc4;
  logic [PC_WIDTH-1:0]  w_ifid_pc4_nx;
  logic [INS_WIDTH-1:0] r_ifid_ins;
  logic [INS_WIDTH-1:0] w_ifid_ins_nx;
  logic                 r_valid;
  logic                 w_valid_nx;

  logic [PC_WIDTH-1:0]  w_pc4;
  logic                 w_fault;
  logic                 w_hlt;

  assign w_pc4   = r_pc + PC_WIDTH'(4);
  assign w_fault = (r_pc[1:0] != 2'b00) ||
                   (r_pc > LP_LAST);
  assign w_hlt   =
    (bus.i_imem_ins[31:21] == 11'b11010100010) &&
    (bus.i_imem_ins[4:0] == 5'd0);

  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_ifid_pc_nx  = r_ifid_pc;
    w_ifid_pc4_nx = r_ifid_pc4;
    w_ifid_ins_nx = r_ifid_ins;
    w_valid_nx    = r_valid;
    unique case (r_state)
      BOOT: begin
        w_valid_nx = 1'b0;
        w_state_nx = RUN;
        if (bus.i_br_taken) w_pc_nx = bus.i_br_target;
      end
      RUN: begin
        if (bus.i_br_taken) begin
          w_pc_nx    = bus.i_br_target;
          w_valid_nx = 1'b0;
        end else if (bus.i_stall) begin
          if (bus.i_flush) w_valid_nx = 1'b0;
        end else if (w_fault) begin
          w_valid_nx = 1'b0;
          w_state_nx = FAULT;
        end else begin
          w_ifid_pc_nx  = r_pc;
          w_ifid_pc4_nx = w_pc4;
          w_ifid_ins_nx = bus.i_imem_ins;
          w_valid_nx    = !bus.i_flush;
          w_pc_nx       = w_pc4;
          // PC already points past the HLT and freezes there
          if (w_hlt && !bus.i_flush) w_state_nx = HALT;
        end
      end
      HALT, FAULT: begin
        w_valid_nx = 1'b0;
        if (bus.i_br_taken) begin
          w_pc_nx    = bus.i_br_target;
          w_state_nx = RUN;
        end
      end
      default: begin
        w_valid_nx = 1'b0;
        w_state_nx = BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_ifid_pc  <= '0;
      r_ifid_pc4 <= '0;
      r_ifid_ins <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_ifid_pc  <= w_ifid_pc_nx;
      r_ifid_pc4 <= w_ifid_pc4_nx;
      r_ifid_ins <= w_ifid_ins_nx;
      r_valid    <= w_valid_nx;
    end
  end

  assign bus.o_imem_add   = r_pc;
  assign bus.o_ifid_pc    = r_ifid_pc;
  assign bus.o_ifid_pc4   = r_ifid_pc4;
  assign bus.o_ifid_ins   = r_ifid_ins;
  assign bus.o_ifid_valid = r_valid;
  assign bus.o_halted     = (r_state == HALT);
  assign bus.o_fault      = (r_state == FAULT);

endmodule
